fht_control_gen: RTL and testbench
==================================

// Module: fht_control_gen
// PURPOSE
//  Parametrised address/control sequencer for an in-place 4-bank radix-2 FHT of N = 2**N_LOG2 points.
//  Drives read/write/coefficient addresses, ping-pong bank write enables and bank-mixer selects for every stage.
//  Next generation of the FHT controller: single clock, configurable size and butterfly pipeline latency,
//  start/abort handshake, done pulse and stage index output.
// PARAMETERS
//  N_LOG2    10          log2 of transform length; N_LOG2 >= 4
//  A_BIT     N_LOG2-2    bank address width; DEPTH = 2**A_BIT words per bank
//  PIPE_LAT  2           cycles from read address to the matching write address (butterfly + RAM latency); >= 1
//  COEF_LAT  1           cycles from read address to coefficient address; < PIPE_LAT
// PORTS
//  iCLK              in   1             single clock
//  iRESET            in   1             synchronous, active-high reset
//  iSTART            in   1             start request; accepted only while oRDY=1
//  iABORT            in   1             abort the running transform
//  oRDY              out  1             idle, ready for iSTART
//  oDONE             out  1             one-cycle pulse when the last stage completes (not on abort)
//  oSTAGE            out  clog2(N_LOG2) current stage s, 0..N_LOG2-1
//  oST_ZERO          out  1             s==0 and running (no multipliers)
//  oST_LAST          out  1             s==N_LOG2-1 and running
//  o2ND_PART_SUBSEC  out  1             read point lies in the second half of its subsector
//  oSECTOR           out  A_BIT         current sector index
//  oADDR_RD_0..3     out  A_BIT each    read addresses; 0/2 linear, 1/3 mirrored
//  oADDR_WR_0..3     out  A_BIT each    write addresses; 0/1 = wr_lo, 2/3 = wr_hi
//  oADDR_COEF        out  A_BIT         coefficient ROM address
//  oWE_A, oWE_B      out  1             write enables for bank sets A/B
//  oSOURCE_DATA      out  1             input mixer bank-set select; toggles every stage
// BEHAVIOUR
//  Reset: oRDY=1. All other outputs 0. FSM enters IDLE. Reset in mid-run aborts immediately.
//  FSM: IDLE -> RUN on iSTART & oRDY. RUN -> FIN after the last stage's final cycle. FIN -> IDLE (1 cycle, oDONE=1).
//   iABORT in RUN or FIN -> IDLE on the next edge: WE low, no oDONE. iABORT wins over every other event.
//   iSTART is ignored outside IDLE. iSTART and iABORT together in IDLE -> stay IDLE.
//  oRDY=0 from the edge that accepts iSTART. oRDY=1 in the same cycle that oDONE pulses.
//  Stage timing: stage counter t = 0..STAGE_LEN-1, with STAGE_LEN = DEPTH + PIPE_LAT + 2.
//   Reads run while t < DEPTH. Writes run while PIPE_LAT <= t < DEPTH+PIPE_LAT.
//   The last 2 cycles are RAM settle time. At t = STAGE_LEN-1: s increments and oSOURCE_DATA toggles.
//  Sector size: SEC_LEN = DEPTH when s==0, otherwise DEPTH >> (s-1). At the last stage SEC_LEN = 1.
//   Sector position: ts = t mod SEC_LEN. oSECTOR = t / SEC_LEN.
//  Reads: linear address = t[A_BIT-1:0].
//   Mirrored address = linear when s<2. Otherwise = oSECTOR*SEC_LEN + ((SEC_LEN - ts) & (SEC_LEN-1)).
//   Read addresses are 0 outside the read window.
//  o2ND_PART_SUBSEC = running & s>=2 & SEC_LEN>=2 & ts >= SEC_LEN/2.
//  Writes: wr_cnt = linear read address delayed by PIPE_LAT. Half flag = o2ND_PART_SUBSEC delayed by PIPE_LAT.
//   If s<2, last stage, or half flag=0: wr_lo = wr_cnt, wr_hi = wr_cnt + SEC_LEN/2.
//   Otherwise: wr_lo = wr_cnt - SEC_LEN/2, wr_hi = wr_cnt.
//   All write arithmetic wraps mod DEPTH. Write addresses are 0 outside the write window.
//   For s<2 and the last stage, wr_hi = wr_cnt.
//  WE: inside the write window, oWE_A=1 on odd s and oWE_B=1 on even s. Never both high.
//  Coefficient address: bit-reverse over A_BIT of oSECTOR, delayed COEF_LAT cycles. Forced to 0 when s==0 or idle.
//  All outputs are registered, except oST_ZERO, oST_LAST and o2ND_PART_SUBSEC (decoded from registers).
// STRUCTURE
//  Package fht_pkg holds:
//   - functions f_clog2 and f_bitrev(A_BIT)
//   - localparams DEPTH and STAGE_LEN
//   - FSM state enum {ST_IDLE, ST_RUN, ST_FIN}
//  Sub-module fht_delay_line #(W, LAT): a reset-clearable shift register.
//   Used for the write address, half flag and coefficient delays.
//   Cleared on iRESET or abort.
// TESTING  (N_LOG2=6, A_BIT=4, PIPE_LAT=2, COEF_LAT=1: DEPTH=16, STAGE_LEN=20)
//  1. Reset for 3 cycles, then release -> oRDY=1 and every other output 0.
//     iSTART while iRESET=1 -> ignored.
//  2. iSTART pulse -> 6 stages x 20 cycles. oDONE high exactly 121 cycles after the accepting edge.
//     oRDY=1 on that same cycle. oSOURCE_DATA toggles 6 times.
//  3. Stage 2 (SEC_LEN=8): oADDR_RD_1 = 0,7,6,5,4,3,2,1,8,15,14,...,9.
//     o2ND_PART_SUBSEC high for ts = 4..7.
//     Write half flag set: wr_lo = wr_cnt-4 and wr_hi = wr_cnt, 2 cycles later.
//  4. WE check: oWE_B high for t = 2..17 in stages 0/2/4; oWE_A high for the same t in stages 1/3/5.
//     Never both high. Exactly 16 writes per stage.
//  5. Stage 3 (SEC_LEN=4): oADDR_COEF = bitrev4(sector) = 0,8,4,12, each held 4 cycles and delayed 1 cycle.
//     Stage 0: oADDR_COEF stays 0.
//  6. iABORT at stage 3, t=7 -> next cycle oRDY=1, WE=0, no oDONE.
//     A following iSTART restarts at stage 0.
//     A second iSTART mid-run has no effect.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared types, defaults and helpers for the FHT
// address/control sequencer.
package fht_pkg;

  localparam int FHT_N_LOG2   = 10;
  localparam int FHT_PIPE_LAT = 2;
  localparam int DEPTH        = 2 ** (FHT_N_LOG2 - 2);
  localparam int STAGE_LEN    = DEPTH + FHT_PIPE_LAT + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  function automatic int f_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Reverses the low w bits of v
  function automatic logic [31:0] f_bitrev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    logic [31:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r = {r[30:0], x[0]};
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_control_gen_if.sv
// Control/address bundle between the FHT sequencer
// and the datapath that consumes it.
interface fht_control_gen_if
  import fht_pkg::*;
#(
  parameter int N_LOG2 = FHT_N_LOG2,
  parameter int A_BIT  = N_LOG2 - 2,
  parameter int SW     = f_clog2(N_LOG2)
);
  logic             iSTART;
  logic             iABORT;
  logic             oRDY;
  logic             oDONE;
  logic [SW-1:0]    oSTAGE;
  logic             oST_ZERO;
  logic             oST_LAST;
  logic             o2ND_PART_SUBSEC;
  logic [A_BIT-1:0] oSECTOR;
  logic [A_BIT-1:0] oADDR_RD_0;
  logic [A_BIT-1:0] oADDR_RD_1;
  logic [A_BIT-1:0] oADDR_RD_2;
  logic [A_BIT-1:0] oADDR_RD_3;
  logic [A_BIT-1:0] oADDR_WR_0;
  logic [A_BIT-1:0] oADDR_WR_1;
  logic [A_BIT-1:0] oADDR_WR_2;
  logic [A_BIT-1:0] oADDR_WR_3;
  logic [A_BIT-1:0] oADDR_COEF;
  logic             oWE_A;
  logic             oWE_B;
  logic             oSOURCE_DATA;

  modport slave (
    input  iSTART, iABORT,
    output oRDY, oDONE, oSTAGE,
    output oST_ZERO, oST_LAST, o2ND_PART_SUBSEC,
    output oSECTOR, oADDR_COEF,
    output oADDR_RD_0, oADDR_RD_1,
    output oADDR_RD_2, oADDR_RD_3,
    output oADDR_WR_0, oADDR_WR_1,
    output oADDR_WR_2, oADDR_WR_3,
    output oWE_A, oWE_B, oSOURCE_DATA
  );

  modport master (
    output iSTART, iABORT,
    input  oRDY, oDONE, oSTAGE,
    input  oST_ZERO, oST_LAST, o2ND_PART_SUBSEC,
    input  oSECTOR, oADDR_COEF,
    input  oADDR_RD_0, oADDR_RD_1,
    input  oADDR_RD_2, oADDR_RD_3,
    input  oADDR_WR_0, oADDR_WR_1,
    input  oADDR_WR_2, oADDR_WR_3,
    input  oWE_A, oWE_B, oSOURCE_DATA
  );
endinterface

// File: rtl/fht_delay_line.sv
// Clearable shift register used to align write
// addresses and coefficients with the butterfly.
module fht_delay_line #(
  parameter int W   = 1,
  parameter int LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_sr [LAT];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < LAT; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < LAT; i++)
        r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[LAT-1];
endmodule

// File: rtl/fht_control_gen.sv
// Address/control sequencer for an in-place 4-bank
// radix-2 FHT; outputs trail the stage counters by one.
module fht_control_gen
  import fht_pkg::*;
#(
  parameter int N_LOG2   = FHT_N_LOG2,
  parameter int A_BIT    = N_LOG2 - 2,
  parameter int PIPE_LAT = FHT_PIPE_LAT,
  parameter int COEF_LAT = 1
) (
  input logic iCLK,
  input logic iRESET,
  fht_control_gen_if.slave bus
);
  localparam int P_DEPTH = 2 ** A_BIT;
  localparam int P_SLEN  = P_DEPTH + PIPE_LAT + 2;
  localparam int SW      = f_clog2(N_LOG2);
  localparam int TW      = f_clog2(P_SLEN);

  localparam logic [TW-1:0] T_LAST = TW'(P_SLEN - 1);
  localparam logic [TW-1:0] T_RDE  = TW'(P_DEPTH);
  localparam logic [TW-1:0] T_WRB  = TW'(PIPE_LAT);
  localparam logic [TW-1:0] T_WRE  =
    TW'(P_DEPTH + PIPE_LAT);
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [A_BIT-1:0] ONES = '1;

  state_t        r_state;
  logic [TW-1:0] r_t;
  logic [SW-1:0] r_s;
  logic          r_rdy;
  logic          r_done;

  logic w_act;
  logic w_abort;
  logic w_clr;

  assign w_act   = (r_state == ST_RUN);
  assign w_abort = bus.iABORT && (r_state != ST_IDLE);
  assign w_clr   = iRESET || w_abort;

  always_ff @(posedge iCLK) begin
    if (iRESET || w_abort) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_s     <= '0;
      r_rdy   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.iSTART && !bus.iABORT) begin
            r_state <= ST_RUN;
            r_t     <= '0;
            r_s     <= '0;
            r_rdy   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (r_t == T_LAST) begin
            r_t <= '0;
            if (r_s == S_LAST) begin
              r_s     <= '0;
              r_state <= ST_FIN;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b1;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sector geometry: SEC_LEN = 2**(A_BIT - w_sh)
  logic [SW-1:0]    w_sh;
  logic [A_BIT-1:0] w_lin;
  logic [A_BIT-1:0] w_m;
  logic [A_BIT-1:0] w_ts;
  logic [A_BIT-1:0] w_neg;
  logic [A_BIT-1:0] w_sec;
  logic [A_BIT-1:0] w_mir;
  logic [A_BIT-1:0] w_hlen;
  logic             w_hi_s;
  logic             w_last;
  logic             w_half_rd;
  logic             w_rd_win;
  logic             w_wr_win;

  assign w_sh   = (r_s == '0) ? '0 : r_s - 1'b1;
  assign w_lin  = r_t[A_BIT-1:0];
  assign w_m    = ONES >> w_sh;
  assign w_ts   = w_lin & w_m;
  assign w_neg  = ~w_ts + 1'b1;
  assign w_sec  = w_lin >> (SW'(A_BIT) - w_sh);
  assign w_hlen = (w_m >> 1) + 1'b1;
  assign w_hi_s = (r_s > S_ONE);
  assign w_last = (r_s == S_LAST);
  assign w_mir  = w_hi_s
    ? ((w_lin & ~w_m) | (w_neg & w_m))
    : w_lin;
  assign w_half_rd = w_act && w_hi_s &&
    ((w_ts & (w_m ^ (w_m >> 1))) != '0);
  assign w_rd_win = w_act && (r_t < T_RDE);
  assign w_wr_win = w_act && (r_t >= T_WRB) &&
    (r_t < T_WRE);

  logic [A_BIT-1:0] w_lin_d;
  logic [A_BIT-1:0] w_coef_d;
  logic [A_BIT-1:0] w_wcnt;
  logic [A_BIT-1:0] w_coef_q;
  logic             w_whalf;

  assign w_lin_d  = w_act ? w_lin : '0;
  assign w_coef_d = (w_act && r_s != '0)
    ? A_BIT'(f_bitrev(32'(w_sec), A_BIT))
    : '0;

  fht_delay_line #(.W(A_BIT), .LAT(PIPE_LAT)) u_dl_wr (
    .i_clk (iCLK),
    .i_clr (w_clr),
    .i_d   (w_lin_d),
    .o_q   (w_wcnt)
  );

  fht_delay_line #(.W(1), .LAT(PIPE_LAT)) u_dl_half (
    .i_clk (iCLK),
    .i_clr (w_clr),
    .i_d   (w_half_rd),
    .o_q   (w_whalf)
  );

  fht_delay_line #(.W(A_BIT), .LAT(COEF_LAT)) u_dl_coef (
    .i_clk (iCLK),
    .i_clr (w_clr),
    .i_d   (w_coef_d),
    .o_q   (w_coef_q)
  );

  logic             w_keep;
  logic [A_BIT-1:0] w_wr_lo;
  logic [A_BIT-1:0] w_wr_hi;

  assign w_keep = !w_hi_s || w_last;

  always_comb begin
    w_wr_lo = w_wcnt;
    w_wr_hi = w_wcnt;
    unique case (1'b1)
      w_keep: begin
        w_wr_lo = w_wcnt;
        w_wr_hi = w_wcnt;
      end
      (!w_keep && !w_whalf):
        w_wr_hi = w_wcnt + w_hlen;
      (!w_keep && w_whalf):
        w_wr_lo = w_wcnt - w_hlen;
    endcase
  end

  logic             r_run;
  logic [SW-1:0]    r_stage;
  logic             r_half;
  logic [A_BIT-1:0] r_sec;
  logic [A_BIT-1:0] r_rd_lin;
  logic [A_BIT-1:0] r_rd_mir;
  logic [A_BIT-1:0] r_wr_lo;
  logic [A_BIT-1:0] r_wr_hi;
  logic [A_BIT-1:0] r_coef;
  logic             r_we_a;
  logic             r_we_b;
  logic             r_src;

  always_ff @(posedge iCLK) begin
    if (iRESET || w_abort) begin
      r_run    <= 1'b0;
      r_stage  <= '0;
      r_half   <= 1'b0;
      r_sec    <= '0;
      r_rd_lin <= '0;
      r_rd_mir <= '0;
      r_wr_lo  <= '0;
      r_wr_hi  <= '0;
      r_coef   <= '0;
      r_we_a   <= 1'b0;
      r_we_b   <= 1'b0;
      r_src    <= 1'b0;
    end else begin
      r_run    <= w_act;
      r_stage  <= w_act ? r_s : '0;
      r_half   <= w_half_rd;
      r_sec    <= w_act ? w_sec : '0;
      r_rd_lin <= w_rd_win ? w_lin : '0;
      r_rd_mir <= w_rd_win ? w_mir : '0;
      r_wr_lo  <= w_wr_win ? w_wr_lo : '0;
      r_wr_hi  <= w_wr_win ? w_wr_hi : '0;
      r_coef   <= w_act ? w_coef_q : '0;
      r_we_a   <= w_wr_win && r_s[0];
      r_we_b   <= w_wr_win && !r_s[0];
      r_src    <= w_act && r_s[0];
    end
  end

  assign bus.oRDY             = r_rdy;
  assign bus.oDONE            = r_done;
  assign bus.oSTAGE           = r_stage;
  assign bus.oST_ZERO         = r_run && (r_stage == '0);
  assign bus.oST_LAST         = r_run && (r_stage == S_LAST);
  assign bus.o2ND_PART_SUBSEC = r_half;
  assign bus.oSECTOR          = r_sec;
  assign bus.oADDR_RD_0       = r_rd_lin;
  assign bus.oADDR_RD_2       = r_rd_lin;
  assign bus.oADDR_RD_1       = r_rd_mir;
  assign bus.oADDR_RD_3       = r_rd_mir;
  assign bus.oADDR_WR_0       = r_wr_lo;
  assign bus.oADDR_WR_1       = r_wr_lo;
  assign bus.oADDR_WR_2       = r_wr_hi;
  assign bus.oADDR_WR_3       = r_wr_hi;
  assign bus.oADDR_COEF       = r_coef;
  assign bus.oWE_A            = r_we_a;
  assign bus.oWE_B            = r_we_b;
  assign bus.oSOURCE_DATA     = r_src;
endmodule

// File: tb/tb_fht_control_gen.sv
// Directed scoreboard bench for fht_control_gen with
// N=64 points (DEPTH=16, STAGE_LEN=20).
module tb_fht_control_gen;
  import fht_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  fht_control_gen_if #(.N_LOG2(6)) bus ();

  fht_control_gen #(
    .N_LOG2   (6),
    .A_BIT    (4),
    .PIPE_LAT (2),
    .COEF_LAT (1)
  ) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic       done;
    logic [2:0] stage;
    logic       stz;
    logic       stl;
    logic       half;
    logic       sec_v;
    logic [3:0] sec;
    logic [3:0] rd_l;
    logic [3:0] rd_m;
    logic [3:0] wlo;
    logic [3:0] whi;
    logic       wea;
    logic       web;
    logic       src;
    logic       coef_v;
    logic [3:0] coef;
  } exp_t;

  exp_t sb[$];
  int   wr_seen[6];
  int   toggles;
  int   done_n;
  int   done_cyc;
  int   start_cyc;
  logic prev_src;

  function automatic int slen(int s);
    return (s == 0) ? 16 : (16 >> (s - 1));
  endfunction

  function automatic logic hrd(int s, int t);
    int l;
    l = slen(s);
    return (s >= 2) && (l >= 2) && ((t % l) >= l / 2);
  endfunction

  function automatic logic [3:0] brev4(int v);
    logic [3:0] x;
    x = v[3:0];
    return {x[0], x[1], x[2], x[3]};
  endfunction

  function automatic exp_t mk_idle(logic rdy, logic done);
    exp_t e;
    e = '0;
    e.rdy    = rdy;
    e.done   = done;
    e.sec_v  = 1'b1;
    e.coef_v = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_run(int s, int t);
    exp_t e;
    int l, ts, sec, cnt, h;
    e   = '0;
    l   = slen(s);
    ts  = t % l;
    sec = t / l;
    h   = l / 2;
    e.stage = 3'(s);
    e.stz   = (s == 0);
    e.stl   = (s == 5);
    e.half  = hrd(s, t);
    e.src   = (s % 2 == 1);
    if (t < 16) begin
      e.sec_v = 1'b1;
      e.sec   = 4'(sec);
      e.rd_l  = 4'(t);
      e.rd_m  = (s < 2) ? 4'(t)
                        : 4'(sec * l + (l - ts) % l);
    end
    if (t >= 2 && t < 18) begin
      cnt   = t - 2;
      e.wea = (s % 2 == 1);
      e.web = (s % 2 == 0);
      e.wlo = 4'(cnt);
      e.whi = 4'(cnt);
      if (s >= 2 && s != 5) begin
        if (hrd(s, cnt)) e.wlo = 4'((cnt - h + 16) % 16);
        else             e.whi = 4'((cnt + h) % 16);
      end
    end
    e.coef_v = (s == 0) || (t >= 1 && t <= 16);
    if (s != 0 && t >= 1 && t <= 16)
      e.coef = brev4((t - 1) / l);
    return e;
  endfunction

  task automatic cmp(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty cyc=%0d", cyc);
      return;
    end
    e = sb.pop_front();
    cmp("rdy",   32'(bus.oRDY), 32'(e.rdy));
    cmp("done",  32'(bus.oDONE), 32'(e.done));
    cmp("stage", 32'(bus.oSTAGE), 32'(e.stage));
    cmp("st_zero", 32'(bus.oST_ZERO), 32'(e.stz));
    cmp("st_last", 32'(bus.oST_LAST), 32'(e.stl));
    cmp("half",  32'(bus.o2ND_PART_SUBSEC), 32'(e.half));
    if (e.sec_v)
      cmp("sector", 32'(bus.oSECTOR), 32'(e.sec));
    cmp("rd0", 32'(bus.oADDR_RD_0), 32'(e.rd_l));
    cmp("rd2", 32'(bus.oADDR_RD_2), 32'(e.rd_l));
    cmp("rd1", 32'(bus.oADDR_RD_1), 32'(e.rd_m));
    cmp("rd3", 32'(bus.oADDR_RD_3), 32'(e.rd_m));
    cmp("wr0", 32'(bus.oADDR_WR_0), 32'(e.wlo));
    cmp("wr1", 32'(bus.oADDR_WR_1), 32'(e.wlo));
    cmp("wr2", 32'(bus.oADDR_WR_2), 32'(e.whi));
    cmp("wr3", 32'(bus.oADDR_WR_3), 32'(e.whi));
    cmp("we_a", 32'(bus.oWE_A), 32'(e.wea));
    cmp("we_b", 32'(bus.oWE_B), 32'(e.web));
    cmp("we_excl", 32'(bus.oWE_A & bus.oWE_B), 32'(0));
    cmp("src", 32'(bus.oSOURCE_DATA), 32'(e.src));
    if (e.coef_v)
      cmp("coef", 32'(bus.oADDR_COEF), 32'(e.coef));
    if (bus.oWE_A || bus.oWE_B)
      wr_seen[int'(e.stage)]++;
    if (bus.oSOURCE_DATA !== prev_src) toggles++;
    prev_src = bus.oSOURCE_DATA;
    if (bus.oDONE === 1'b1) begin
      done_n++;
      done_cyc = cyc - start_cyc;
    end
  endtask

  task automatic tick_chk();
    @(posedge clk);
    #1;
    cyc++;
    pop_check();
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 6; i++) wr_seen[i] = 0;
    toggles  = 0;
    done_n   = 0;
    done_cyc = -1;
    prev_src = bus.oSOURCE_DATA;
  endtask

  // Full transform; mid > 0 re-pulses iSTART mid-run
  task automatic full_run(input int mid);
    clr_stats();
    sb.push_back(mk_idle(1'b0, 1'b0));
    for (int k = 0; k < 120; k++)
      sb.push_back(mk_run(k / 20, k % 20));
    sb.push_back(mk_idle(1'b1, 1'b1));
    sb.push_back(mk_idle(1'b1, 1'b0));
    bus.iSTART = 1'b1;
    start_cyc = cyc + 1;
    for (int k = 0; k < 123; k++) begin
      tick_chk();
      bus.iSTART = (mid > 0) && (k + 1 == mid);
    end
    bus.iSTART = 1'b0;
    cmp("done_count", 32'(done_n), 32'(1));
    cmp("done_latency", 32'(done_cyc), 32'(121));
    cmp("src_toggles", 32'(toggles), 32'(6));
    for (int i = 0; i < 6; i++)
      cmp($sformatf("writes_s%0d", i),
          32'(wr_seen[i]), 32'(16));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    start_cyc  = 0;
    rst        = 1'b1;
    bus.iSTART = 1'b1;
    bus.iABORT = 1'b0;

    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk_idle(1'b1, 1'b0));
      tick_chk();
    end
    rst        = 1'b0;
    bus.iSTART = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk_idle(1'b1, 1'b0));
      tick_chk();
    end

    full_run(0);

    clr_stats();
    sb.push_back(mk_idle(1'b0, 1'b0));
    for (int k = 0; k < 68; k++)
      sb.push_back(mk_run(k / 20, k % 20));
    bus.iSTART = 1'b1;
    tick_chk();
    bus.iSTART = 1'b0;
    for (int k = 0; k < 68; k++) tick_chk();
    bus.iABORT = 1'b1;
    sb.push_back(mk_idle(1'b1, 1'b0));
    tick_chk();
    bus.iABORT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk_idle(1'b1, 1'b0));
      tick_chk();
    end
    cmp("abort_no_done", 32'(done_n), 32'(0));

    bus.iSTART = 1'b1;
    bus.iABORT = 1'b1;
    sb.push_back(mk_idle(1'b1, 1'b0));
    tick_chk();
    bus.iSTART = 1'b0;
    bus.iABORT = 1'b0;
    sb.push_back(mk_idle(1'b1, 1'b0));
    tick_chk();

    full_run(40);

    cmp("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
